// File: rtl/act_lut_arbiter_if.sv
// ----------------------------------------------------------------------------
// act_lut_arbiter_if
// Requester-side and LUT-SRAM-side signals of the activation LUT arbiter.
// The arbiter connects through the slave modport. The environment (the
// interpolation units and the SRAM macro) connects through the master modport.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface act_lut_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      tanh_read_en;
  logic [ADDR_W-1:0]         tanh_read_address;
  logic [DATA_W-1:0]         tanh_read_data;
  logic                      arb_busy;

  modport slave (
    input  req, req_lock, req_addr, tanh_read_data,
    output gnt, rsp_valid, rsp_data, tanh_read_en, tanh_read_address, arb_busy
  );

  modport master (
    output req, req_lock, req_addr, tanh_read_data,
    input  gnt, rsp_valid, rsp_data, tanh_read_en, tanh_read_address, arb_busy
  );
endinterface

`default_nettype wire

// File: rtl/act_lut_arbiter.sv
// ----------------------------------------------------------------------------
// act_lut_arbiter
// Round-robin arbiter that shares the activation LUT SRAM read port among
// NUM_REQ interpolation units. It supports a two-read lock, so that y0 and y1
// are read back-to-back, and tag-based routing of the returned data.
// Optional macro ACT_LUT_PRIO0_EN gives requester 0 fixed top priority
// outside of a lock.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module act_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1
) (
  input  wire logic          clk,
  input  wire logic          reset_b,
  act_lut_arbiter_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic [NUM_REQ-1:0] gnt_rr;
  logic [NUM_REQ-1:0] gnt_lock;
  logic [NUM_REQ-1:0] gnt;
  logic               lock_act;
  logic               rr_found;
  int                 scan;
  logic               hs;
  logic [IDX_W-1:0]   hs_idx;

  // Read issue and tag pipeline. Stage k holds the read issued k+1 cycles ago.
  logic               rd_en_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [RD_LAT:0]    tag_v_q;
  logic [IDX_W-1:0]   tag_idx_q [RD_LAT+1];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [NUM_REQ-1:0] rsp_oh;
  logic [DATA_W-1:0]  rsp_data_q;

  // Grant selection: the held lock wins, otherwise round-robin from the pointer.
  always_comb begin
    gnt_rr   = '0;
    rr_found = 1'b0;
    scan     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!rr_found && bus.req[scan]) begin
        gnt_rr[scan] = 1'b1;
        rr_found     = 1'b1;
      end
    end
`ifdef ACT_LUT_PRIO0_EN
    if (bus.req[0]) gnt_rr = {{(NUM_REQ-1){1'b0}}, 1'b1};
`endif
    gnt_lock             = '0;
    gnt_lock[lock_idx_q] = 1'b1;
    // An abandoned lock falls straight through to normal arbitration.
    lock_act = (state_q == S_LOCKED) && bus.req[lock_idx_q];
    if (!reset_b)      gnt = '0;
    else if (lock_act) gnt = gnt_lock;
    else               gnt = gnt_rr;
  end

  // Handshake detection and encoding of the accepted requester.
  always_comb begin
    hs     = |(bus.req & gnt);
    hs_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (bus.req[k] && gnt[k]) hs_idx = IDX_W'(k);
    end
  end

  // Next-state logic for the arbitration state, pointer and lock owner.
  always_comb begin
    state_d    = (|bus.req) ? S_GRANT : S_IDLE;
    ptr_d      = ptr_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      ptr_d = (int'(hs_idx) == NUM_REQ - 1) ? '0 : hs_idx + 1'b1;
      // A lock may only start on an unlocked handshake, so at most two reads are paired.
      if (!lock_act && bus.req_lock[hs_idx]) begin
        state_d    = S_LOCKED;
        lock_idx_d = hs_idx;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // One-hot owner of the read whose data arrives this cycle.
  always_comb begin
    rsp_oh                      = '0;
    rsp_oh[tag_idx_q[RD_LAT]] = 1'b1;
  end

  // SRAM strobe, owner-tag shift register and response capture.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      tag_v_q     <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_idx_q[k] <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rd_en_q <= hs;
      if (hs) rd_addr_q <= bus.req_addr[hs_idx*ADDR_W +: ADDR_W];
      tag_v_q[0]   <= hs;
      tag_idx_q[0] <= hs_idx;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1];
        tag_idx_q[k] <= tag_idx_q[k-1];
      end
      rsp_valid_q <= tag_v_q[RD_LAT] ? rsp_oh : '0;
      if (tag_v_q[RD_LAT]) rsp_data_q <= bus.tanh_read_data;
    end
  end

  assign bus.gnt               = gnt;
  assign bus.tanh_read_en      = rd_en_q;
  assign bus.tanh_read_address = rd_addr_q;
  assign bus.rsp_valid         = rsp_valid_q;
  assign bus.rsp_data          = rsp_data_q;
  assign bus.arb_busy          = (|tag_v_q) | rd_en_q;

endmodule

`default_nettype wire

// File: doc/act_lut_arbiter.md
Name: act_lut_arbiter

Overview:
- Shares the single read port of the activation LUT SRAM (tanh/sigmoid sample table, 16-bit entries at even byte addresses) among NUM_REQ interpolation units.
- Uses round-robin arbitration with a two-read lock, so each interpolator gets its y0/y1 neighbouring samples back-to-back.
- Tags each issued read and routes the returned data back to the requester that issued it.
- Sits between the interpolation units and the LUT SRAM macro.

Parameters:
- NUM_REQ, 4, number of requesting interpolation units (2..8).
- ADDR_W, 12, LUT byte-address width.
- DATA_W, 16, LUT data width.
- RD_LAT, 1, SRAM read latency in cycles from tanh_read_en to valid tanh_read_data (1..3).

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset_b  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester read request; level, held until granted.
- req_lock  input  NUM_REQ  per-requester "next read follows"; sampled only in that requester's handshake cycle.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- gnt  output  NUM_REQ  one-hot acceptance, combinational; a handshake occurs in any cycle where req[i] & gnt[i].
- rsp_valid  output  NUM_REQ  one-hot, registered; high one cycle when rsp_data belongs to requester i.
- rsp_data  output  DATA_W  registered returned LUT word, broadcast to all requesters.
- tanh_read_en  output  1  registered SRAM read strobe.
- tanh_read_address  output  ADDR_W  registered SRAM address.
- tanh_read_data  input  DATA_W  SRAM read data, valid RD_LAT cycles after tanh_read_en.
- arb_busy  output  1  high while any read is outstanding in the tag pipeline.

Behaviour:
- Interface rules:
  - One clock; reset is synchronous and active-low; clock and reset ports are named clk and reset_b.
  - Sampled at posedge with reset_b=0:
    - gnt, rsp_valid, rsp_data, tanh_read_en, tanh_read_address and arb_busy all go to 0.
    - The round-robin pointer goes to 0 (requester 0 has highest priority).
    - The lock state and the tag pipeline are cleared.
  - Reset mid-operation drops all outstanding reads. No rsp_valid is issued for them, even if the SRAM returns data.
- States: IDLE, GRANT, LOCKED.
  - IDLE: no req asserted; gnt=0.
  - GRANT: at least one req is high and no lock is held.
    - gnt = first asserted req at or after the pointer, scanning upward and wrapping NUM_REQ-1 -> 0.
    - On a handshake by requester i, the pointer becomes (i+1) mod NUM_REQ.
  - LOCKED: entered on the edge after a handshake by requester i with req_lock[i]=1.
    - gnt is forced to 1<<i when req[i]=1; all other requesters see gnt=0.
    - A handshake here returns to GRANT, and the pointer becomes (i+1) mod NUM_REQ.
    - req_lock during a LOCKED handshake is ignored: at most 2 consecutive grants per lock.
    - If req[i]=0 while LOCKED, the lock is released in that same cycle and GRANT arbitration applies combinationally.
- Read timing:
  - Handshake in cycle c -> tanh_read_en=1 and tanh_read_address=req_addr[i] in cycle c+1.
  - tanh_read_data is captured in cycle c+1+RD_LAT.
  - rsp_valid[i]=1 and rsp_data are driven in cycle c+2+RD_LAT; total latency with RD_LAT=1 is 3 cycles.
- Throughput and ordering:
  - Maximum throughput is one read per cycle, with responses in issue order.
  - A tag shift register (valid + index, depth RD_LAT+1) carries ownership of each read.
- arb_busy = OR of tag-pipeline valid bits, plus tanh_read_en.
- The address is passed unmodified; no alignment check is done (requesters supply even addresses).
- With no handshake, tanh_read_en=0 and tanh_read_address holds its last value.
- gnt must never be multi-hot, and never high for a requester whose req is low.

Optional Feature:
- Macro: ACT_LUT_PRIO0_EN.
- When defined, requester 0 has fixed top priority in GRANT: if req[0]=1, then gnt=1.
  - An active LOCKED grant to another requester still completes first.
  - Round-robin among 1..NUM_REQ-1 is otherwise unchanged.
- When undefined, requester 0 is an ordinary round-robin participant.

Test Plan:
- Single read (RD_LAT=1): req[2]=1, addr=0x1A4, SRAM returns 0x3F21 -> tanh_read_en in c+1 with address 0x1A4; rsp_valid=0b0100 and rsp_data=0x3F21 in c+3; arb_busy high for c+1..c+2.
- All four req held continuously with req_lock=0, from reset -> gnt sequence 0,1,2,3,0,1 on consecutive cycles; responses return in the same order at 3-cycle latency.
- Lock pair: req[1] with lock=1 at addr 0x040, req[3] also pending -> two consecutive grants to requester 1 (0x040, then 0x042), then requester 3; requester 1's second req_lock is ignored.
- Lock abandoned: requester 1 handshakes with lock=1, then drops req -> requester 3 is granted in that same cycle.
- Reset during traffic: reset_b=0 one cycle after a handshake -> no rsp_valid is ever issued for that read; the pointer restarts at 0.
- With ACT_LUT_PRIO0_EN defined: req=0b1111 held -> requester 0 wins every cycle that is not LOCKED.
